// File: rtl/alu_predictor_stream_if.sv
// Operation and result streams of the ALU predictor, both valid/ready.
// The predictor uses the slave view; the bench or stimulus side uses master.
interface alu_predictor_stream_if #(
  parameter int unsigned DATA_W = 8
);
  logic                  op_valid;
  logic                  op_ready;
  logic [2:0]            op_code;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [2*DATA_W-1:0]   res_data;

  modport master (
    output op_valid, op_code, op_a, op_b, res_ready,
    input  op_ready, res_valid, res_data
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, res_ready,
    output op_ready, res_valid, res_data
  );
endinterface

// File: rtl/alu_predictor_stream.sv
// Expected-result generator for TinyALU: computes each op's result with
// multi-cycle mul timing and queues it in a first-word-fall-through FIFO.
module alu_predictor_stream #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alu_predictor_stream_if.slave bus,
  output logic                 err_bad_op,
  output logic [2:0]           err_op,
  output logic [CNT_W-1:0]     op_count,
  output logic [CNT_W-1:0]     res_count
);

  localparam int unsigned ResW = 2 * DATA_W;
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FcW  = $clog2(DEPTH) + 1;
  localparam int unsigned LatW = $clog2(MUL_LAT + 1);

  localparam logic [2:0] OpNop = 3'd0;
  localparam logic [2:0] OpAdd = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpXor = 3'd3;
  localparam logic [2:0] OpMul = 3'd4;

  typedef enum logic {StIdle, StExec} state_e;

  state_e              state_q, state_d;
  logic [LatW-1:0]     lat_q, lat_d;
  logic [2:0]          code_q, code_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;

  logic [ResW-1:0]     mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FcW-1:0]      fifo_cnt_q;
  logic [ResW-1:0]     last_q;

  logic                err_bad_q;
  logic [2:0]          err_op_q;
  logic [CNT_W-1:0]    op_cnt_q;
  logic [CNT_W-1:0]    res_cnt_q;

  logic                accept, legal, push, pop;
  logic [ResW-1:0]     result;

  assign bus.op_ready = (state_q == StIdle) && (fifo_cnt_q < FcW'(DEPTH));
  assign accept       = bus.op_valid && bus.op_ready;
  assign legal        = (bus.op_code <= OpMul);
  assign pop          = (fifo_cnt_q != '0) && bus.res_ready;

  assign bus.res_valid = (fifo_cnt_q != '0);
  // When empty, keep presenting the most recently popped entry.
  assign bus.res_data  = bus.res_valid ? mem_q[rd_ptr_q] : last_q;

  assign err_bad_op = err_bad_q;
  assign err_op     = err_op_q;
  assign op_count   = op_cnt_q;
  assign res_count  = res_cnt_q;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    code_d  = code_q;
    a_d     = a_q;
    b_d     = b_q;
    push    = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          code_d = bus.op_code;
          a_d    = bus.op_a;
          b_d    = bus.op_b;
          if (bus.op_code == OpAdd || bus.op_code == OpAnd || bus.op_code == OpXor) begin
            state_d = StExec;
            lat_d   = LatW'(1);
          end else if (bus.op_code == OpMul) begin
            state_d = StExec;
            lat_d   = LatW'(MUL_LAT);
          end
        end
      end
      StExec: begin
        lat_d = lat_q - LatW'(1);
        if (lat_q == LatW'(1)) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    result = '0;
    case (code_q)
      OpAdd:   result = ResW'(a_q) + ResW'(b_q);
      OpAnd:   result = ResW'(a_q & b_q);
      OpXor:   result = ResW'(a_q ^ b_q);
      OpMul:   result = ResW'(a_q) * ResW'(b_q);
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      lat_q   <= '0;
      code_q  <= OpNop;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      code_q  <= code_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Push and pop may coincide at any occupancy; push never sees a full FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      last_q     <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= result;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + FcW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - FcW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_bad_q <= 1'b0;
      err_op_q  <= 3'd0;
      op_cnt_q  <= '0;
      res_cnt_q <= '0;
    end else begin
      if (accept) begin
        op_cnt_q <= op_cnt_q + CNT_W'(1);
      end
      if (pop) begin
        res_cnt_q <= res_cnt_q + CNT_W'(1);
      end
      if (accept && !legal && !err_bad_q) begin
        err_bad_q <= 1'b1;
        err_op_q  <= bus.op_code;
      end
    end
  end

endmodule

// File: tb/tb_alu_predictor_stream.sv
// Directed bench for alu_predictor_stream: inputs driven and outputs checked on
// the falling edge, with a second narrow-counter instance for wrap checking.
module tb_alu_predictor_stream;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  logic [7:0]  w_err_op_unused_a;
  logic [2:0]  err_op, w_err_op;
  logic        err_bad_op, w_err_bad_op;
  logic [15:0] op_count, res_count;
  logic [3:0]  w_op_count, w_res_count;

  alu_predictor_stream_if #(.DATA_W(8)) bus ();
  alu_predictor_stream_if #(.DATA_W(8)) w_bus ();

  alu_predictor_stream #(
    .DATA_W (8),
    .MUL_LAT(3),
    .DEPTH  (4),
    .CNT_W  (16)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .err_bad_op(err_bad_op),
    .err_op    (err_op),
    .op_count  (op_count),
    .res_count (res_count)
  );

  alu_predictor_stream #(
    .DATA_W (8),
    .MUL_LAT(3),
    .DEPTH  (4),
    .CNT_W  (4)
  ) u_dut_w (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (w_bus),
    .err_bad_op(w_err_bad_op),
    .err_op    (w_err_op),
    .op_count  (w_op_count),
    .res_count (w_res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an op, wait (bounded) for op_ready, let it be accepted, then drop valid.
  task automatic issue(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bus.op_valid = 1'b1;
    bus.op_code  = c;
    bus.op_a     = a;
    bus.op_b     = b;
    while (!bus.op_ready && n < 30) begin
      step();
      n++;
    end
    chk("issue_ready", 32'(bus.op_ready), 32'd1);
    step();
    bus.op_valid = 1'b0;
  endtask

  initial begin
    int  got;
    logic acc;
    total = 0;
    bad   = 0;
    w_err_op_unused_a = '0;
    reset_n = 1'b0;
    bus.op_valid = 1'b0;  bus.op_code = 3'd0;  bus.op_a = '0;  bus.op_b = '0;
    bus.res_ready = 1'b0;
    w_bus.op_valid = 1'b0; w_bus.op_code = 3'd0; w_bus.op_a = '0; w_bus.op_b = '0;
    w_bus.res_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_op_ready",  32'(bus.op_ready),  32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data",  32'(bus.res_data),  32'd0);
    chk("rst_err_bad",   32'(err_bad_op),    32'd0);
    chk("rst_err_op",    32'(err_op),        32'd0);
    chk("rst_op_count",  32'(op_count),      32'd0);
    chk("rst_res_count", 32'(res_count),     32'd0);
    reset_n = 1'b1;
    step();

    // add with carry out, single-cycle latency, immediate pop
    bus.res_ready = 1'b1;
    issue(3'b001, 8'hFF, 8'h01);
    chk("add_busy",      32'(bus.op_ready),  32'd0);
    chk("add_opcnt",     32'(op_count),      32'd1);
    chk("add_novalid",   32'(bus.res_valid), 32'd0);
    step();
    chk("add_valid",     32'(bus.res_valid), 32'd1);
    chk("add_data",      32'(bus.res_data),  32'h0100);
    step();
    chk("add_popped",    32'(bus.res_valid), 32'd0);
    chk("add_rescnt",    32'(res_count),     32'd1);
    chk("add_hold",      32'(bus.res_data),  32'h0100);
    bus.res_ready = 1'b0;

    // mul latency, then and/xor queued behind it
    issue(3'b100, 8'hFF, 8'hFF);
    chk("mul_busy1", 32'(bus.op_ready), 32'd0);
    step();
    chk("mul_busy2", 32'(bus.op_ready), 32'd0);
    step();
    chk("mul_busy3", 32'(bus.op_ready), 32'd0);
    chk("mul_notyet", 32'(bus.res_valid), 32'd0);
    step();
    chk("mul_ready", 32'(bus.op_ready),  32'd1);
    chk("mul_valid", 32'(bus.res_valid), 32'd1);
    chk("mul_data",  32'(bus.res_data),  32'hFE01);
    issue(3'b010, 8'hF0, 8'h3C);
    issue(3'b011, 8'hAA, 8'h55);
    step();
    bus.res_ready = 1'b1;
    chk("ord_mul", 32'(bus.res_data), 32'hFE01);
    step();
    chk("ord_and", 32'(bus.res_data), 32'h0030);
    step();
    chk("ord_xor", 32'(bus.res_data), 32'h00FF);
    step();
    chk("ord_empty",  32'(bus.res_valid), 32'd0);
    chk("ord_hold",   32'(bus.res_data),  32'h00FF);
    chk("ord_rescnt", 32'(res_count),     32'd4);
    chk("ord_opcnt",  32'(op_count),      32'd4);

    // Fill the FIFO, stall a fifth op, then drain in order
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(3'b001, 8'h10 + 8'(i), 8'h20);
    end
    step();
    chk("full_ready", 32'(bus.op_ready),  32'd0);
    chk("full_valid", 32'(bus.res_valid), 32'd1);
    chk("full_head",  32'(bus.res_data),  32'h0030);
    bus.op_valid = 1'b1;
    bus.op_code  = 3'b001;
    bus.op_a     = 8'h14;
    bus.op_b     = 8'h20;
    step();
    chk("full_stall1", 32'(bus.op_ready), 32'd0);
    step();
    chk("full_stall2", 32'(bus.op_ready), 32'd0);
    bus.res_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 40 && got < 5; n++) begin
      if (bus.res_valid) begin
        chk($sformatf("fifo_order%0d", got), 32'(bus.res_data), 32'h30 + 32'(got));
        got++;
      end
      acc = bus.op_valid && bus.op_ready;
      step();
      if (acc) bus.op_valid = 1'b0;
    end
    chk("fifo_drained",  32'(got),       32'd5);
    chk("fifo_rescnt",   32'(res_count), 32'd9);
    chk("fifo_opcnt",    32'(op_count),  32'd9);

    // no_op and illegal ops: counted, no result, first illegal code kept
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    issue(3'b000, 8'h00, 8'h00);
    issue(3'b110, 8'h00, 8'h00);
    chk("ill_flag",  32'(err_bad_op), 32'd1);
    issue(3'b111, 8'h00, 8'h00);
    issue(3'b001, 8'h01, 8'h02);
    chk("ill_opcnt", 32'(op_count),   32'd4);
    chk("ill_sticky", 32'(err_bad_op), 32'd1);
    chk("ill_first", 32'(err_op),     32'd6);
    step();
    chk("ill_valid", 32'(bus.res_valid), 32'd1);
    chk("ill_data",  32'(bus.res_data),  32'h0003);
    step();
    chk("ill_single", 32'(bus.res_valid), 32'd0);
    chk("ill_rescnt", 32'(res_count),     32'd1);

    // Reset during mul execution with two results queued
    bus.res_ready = 1'b0;
    issue(3'b001, 8'h01, 8'h01);
    issue(3'b001, 8'h02, 8'h02);
    issue(3'b100, 8'h03, 8'h03);
    chk("mr_queued", 32'(bus.res_valid), 32'd1);
    chk("mr_busy",   32'(bus.op_ready),  32'd0);
    reset_n = 1'b0;
    #1;
    chk("mr_async_valid", 32'(bus.res_valid), 32'd0);
    chk("mr_async_opcnt", 32'(op_count),      32'd0);
    step();
    reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      chk("mr_no_stale", 32'(bus.res_valid), 32'd0);
    end
    chk("mr_ready",  32'(bus.op_ready),  32'd1);
    chk("mr_opcnt",  32'(op_count),      32'd0);
    chk("mr_rescnt", 32'(res_count),     32'd0);
    chk("mr_err",    32'(err_bad_op),    32'd0);
    chk("mr_data",   32'(bus.res_data),  32'd0);

    // 4-bit op counter wraps after 16 accepted no_ops
    w_bus.op_valid = 1'b1;
    w_bus.op_code  = 3'b000;
    for (int n = 0; n < 16; n++) step();
    chk("wrap_16", 32'(w_op_count), 32'd0);
    step();
    w_bus.op_valid = 1'b0;
    chk("wrap_17", 32'(w_op_count), 32'd1);
    chk("wrap_novalid", 32'(w_bus.res_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
